// File: rtl/shseq_pkg.sv
// Shared definitions for the shift-register sequencer:
// shift-register MODE encodings, command opcodes and FSM states.
package shseq_pkg;

    // MODE encodings driven to the external shift register
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_SHR      = 2'b01;
    localparam logic [1:0] OP_SHL      = 2'b10;
    localparam logic [1:0] OP_LOAD_SHR = 2'b11;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_ST    = 3'd1,
        SHIFT_ST   = 3'd2,
        CAPTURE_ST = 3'd3,
        DONE_ST    = 3'd4
    } state_t;

    // Shift direction for a shifting opcode (LOAD_SHR always shifts right)
    function automatic logic [1:0] shift_mode(input logic [1:0] op);
        return (op == OP_SHL) ? MODE_SHL : MODE_SHR;
    endfunction

endpackage

// File: rtl/shiftreg_sequencer_if.sv
// Command / result bus of the shift-register sequencer.
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high; the master holds cmd_op/cmd_data/cmd_count stable
// while cmd_valid is high and not yet accepted. result_valid is a one-cycle
// strobe with no back-pressure; result_data holds until the next strobe.
interface shiftreg_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH) + 1
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CW-1:0]    cmd_count;
    logic             result_valid;
    logic [WIDTH-1:0] result_data;

    // Command issuer / result consumer
    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count,
        input  cmd_ready, result_valid, result_data
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count,
        output cmd_ready, result_valid, result_data
    );
endinterface

// File: rtl/shseq_shift_counter.sv
// Down-counter holding the remaining shift count of the current command.
// A load saturates values above WIDTH to WIDTH; dec stops at zero.
module shseq_shift_counter #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          is_one
);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    // Load (with saturation) takes priority over decrement
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val > CNT_MAX) ? CNT_MAX : load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign is_one = (cnt == CW'(1));

endmodule

// File: rtl/shiftreg_sequencer.sv
// Command-driven controller for one external universal shift register.
// Accepts LOAD / SHR / SHL / LOAD_SHR commands, drives MODE/DATAIN for the
// required number of cycles, then captures DATAOUT and strobes the result.
// Optional feature: define SHSEQ_PERF_CNT_EN to add the op_count[15:0]
// completed-command counter.
module shiftreg_sequencer
    import shseq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    shiftreg_sequencer_if.slave cmd,
    output logic [1:0]       MODE,
    output logic [WIDTH-1:0] DATAIN,
    input  logic [WIDTH-1:0] DATAOUT,
    output logic             busy,
    output state_t           state_dbg
`ifdef SHSEQ_PERF_CNT_EN
    ,
    output logic [15:0]      op_count
`endif
);

    state_t           state;
    logic [1:0]       op_q;
    logic             ready_q;
    logic             busy_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] datain_q;

    logic             accept;
    logic             cnt_load;
    logic [CW-1:0]    cnt_load_val;
    logic             cnt_dec;
    logic [CW-1:0]    cnt;
    logic             cnt_is_one;

    assign accept       = cmd.cmd_valid && ready_q;
    assign cnt_load     = accept;
    // A plain LOAD ignores cmd_count, so the counter is cleared for it
    assign cnt_load_val = (cmd.cmd_op == OP_LOAD) ? '0 : cmd.cmd_count;
    assign cnt_dec      = (state == SHIFT_ST);

    shseq_shift_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .is_one   (cnt_is_one)
    );

    // Main FSM; every output is a register updated here
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_q        <= OP_LOAD;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            mode_q      <= MODE_HOLD;
            datain_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    res_valid_q <= 1'b0;
                    if (accept) begin
                        op_q    <= cmd.cmd_op;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if ((cmd.cmd_op == OP_LOAD) || (cmd.cmd_op == OP_LOAD_SHR)) begin
                            state    <= LOAD_ST;
                            mode_q   <= MODE_LOAD;
                            datain_q <= cmd.cmd_data;
                        end else if (cmd.cmd_count != '0) begin
                            state  <= SHIFT_ST;
                            mode_q <= shift_mode(cmd.cmd_op);
                        end else begin
                            state  <= CAPTURE_ST;
                            mode_q <= MODE_HOLD;
                        end
                    end
                end
                LOAD_ST: begin
                    if ((op_q == OP_LOAD_SHR) && (cnt != '0)) begin
                        state  <= SHIFT_ST;
                        mode_q <= MODE_SHR;
                    end else begin
                        state  <= CAPTURE_ST;
                        mode_q <= MODE_HOLD;
                    end
                end
                SHIFT_ST: begin
                    // Last shift cycle: drop MODE so the register holds its result
                    if (cnt_is_one) begin
                        state  <= CAPTURE_ST;
                        mode_q <= MODE_HOLD;
                    end
                end
                CAPTURE_ST: begin
                    res_data_q  <= DATAOUT;
                    res_valid_q <= 1'b1;
                    state       <= DONE_ST;
                end
                DONE_ST: begin
                    res_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mode_q  <= MODE_HOLD;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHSEQ_PERF_CNT_EN
    // Count completed commands, one per result strobe, wrapping at 16 bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_count <= '0;
        end else if (res_valid_q) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

    assign cmd.cmd_ready    = ready_q;
    assign cmd.result_valid = res_valid_q;
    assign cmd.result_data  = res_data_q;
    assign MODE             = mode_q;
    assign DATAIN           = datain_q;
    assign busy             = busy_q;
    assign state_dbg        = state;

endmodule

// File: tb/tb_shiftreg_sequencer.sv
// Directed testbench for shiftreg_sequencer (WIDTH=4) with a behavioural
// zero-fill universal shift register closing the MODE/DATAIN/DATAOUT loop.
module tb_shiftreg_sequencer;
    import shseq_pkg::*;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH) + 1;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT and shift register ----------------
    shiftreg_sequencer_if #(.WIDTH(WIDTH), .CW(CW)) cmd_bus ();

    logic [1:0]       MODE;
    logic [WIDTH-1:0] DATAIN;
    logic [WIDTH-1:0] DATAOUT;
    logic             busy;
    state_t           state_dbg;
`ifdef SHSEQ_PERF_CNT_EN
    logic [15:0]      op_count;
`endif

    shiftreg_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd       (cmd_bus.slave),
        .MODE      (MODE),
        .DATAIN    (DATAIN),
        .DATAOUT   (DATAOUT),
        .busy      (busy),
        .state_dbg (state_dbg)
`ifdef SHSEQ_PERF_CNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    // Universal shift register: 00 hold, 01 right, 10 left, 11 load
    logic [WIDTH-1:0] sr_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            case (MODE)
                2'b01:   sr_q <= sr_q >> 1;
                2'b10:   sr_q <= sr_q << 1;
                2'b11:   sr_q <= DATAIN;
                default: sr_q <= sr_q;
            endcase
        end
    end
    assign DATAOUT = sr_q;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] mode_trace[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int count_mode(input logic [1:0] m);
        int n = 0;
        foreach (mode_trace[i]) if (mode_trace[i] == m) n++;
        return n;
    endfunction

    // ---------------- driver ----------------
    // Issue one command and follow it to its result. lat counts cycles with
    // the cycle right after the accept edge as cycle 1.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data,
                           input logic [CW-1:0] count,
                           output int lat, output logic [3:0] res);
        @(negedge clock);
        check("ready_before_cmd", cmd_bus.cmd_ready, 1);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_data  = data;
        cmd_bus.cmd_count = count;
        @(posedge clock);
        @(negedge clock);
        cmd_bus.cmd_valid = 1'b0;
        mode_trace.delete();
        lat = 0;
        res = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) @(negedge clock);
            mode_trace.push_back(MODE);
            if (cmd_bus.result_valid) begin
                lat = cyc;
                res = cmd_bus.result_data;
                break;
            end
        end
        if (lat == 0) check("result_timeout", lat, 1);
        @(negedge clock);
        check("result_pulse_one_cycle", cmd_bus.result_valid, 0);
        check("idle_after_done", state_dbg, IDLE);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int         lat;
    logic [3:0] res;
    logic       saw_valid;

    initial begin
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = 2'b00;
        cmd_bus.cmd_data  = '0;
        cmd_bus.cmd_count = '0;

        // 1. reset held two cycles, then released
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_mode", MODE, 2'b00);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mode_after", MODE, 2'b00);
        check("rst_datain", DATAIN, 4'b0000);
        check("rst_ready", cmd_bus.cmd_ready, 1);
        check("rst_busy_after", busy, 0);
        check("rst_result_valid", cmd_bus.result_valid, 0);
        check("rst_result_data", cmd_bus.result_data, 4'b0000);
        check("rst_state", state_dbg, IDLE);

        // 2. LOAD 1010
        run_cmd(OP_LOAD, 4'b1010, 3'd0, lat, res);
        check("load_latency", lat, 3);
        check("load_result", res, 4'b1010);
        check("load_mode11_cycles", count_mode(2'b11), 1);
        check("load_trace0", mode_trace[0], 2'b11);
        check("load_datain", DATAIN, 4'b1010);

        // 4. SHL count=0 right after the LOAD: MODE stays at hold
        run_cmd(OP_SHL, 4'b0101, 3'd0, lat, res);
        check("shl0_latency", lat, 2);
        check("shl0_result", res, 4'b1010);
        check("shl0_mode_nonhold", mode_trace.size() - count_mode(2'b00), 0);
        check("shl0_datain_unchanged", DATAIN, 4'b1010);

        // 3. LOAD_SHR data=1011 count=2
        run_cmd(OP_LOAD_SHR, 4'b1011, 3'd2, lat, res);
        check("lshr_latency", lat, 5);
        check("lshr_result", res, 4'b0010);
        check("lshr_trace0", mode_trace[0], 2'b11);
        check("lshr_trace1", mode_trace[1], 2'b01);
        check("lshr_trace2", mode_trace[2], 2'b01);
        check("lshr_trace3", mode_trace[3], 2'b00);

        // 5. LOAD 1111 then SHR count=7 (saturates to 4)
        run_cmd(OP_LOAD, 4'b1111, 3'd5, lat, res);
        check("load1111_result", res, 4'b1111);
        run_cmd(OP_SHR, 4'b0000, 3'd7, lat, res);
        check("shr_sat_mode01_cycles", count_mode(2'b01), 4);
        check("shr_sat_latency", lat, 6);
        check("shr_sat_result", res, 4'b0000);
        check("result_data_held", cmd_bus.result_data, 4'b0000);

`ifdef SHSEQ_PERF_CNT_EN
        check("perf_count_5", op_count, 16'd5);
`endif

        // 6. reset during SHIFT_ST of SHL count=3
        run_cmd(OP_LOAD, 4'b0011, 3'd0, lat, res);
        check("pre_reset_load", res, 4'b0011);
        @(negedge clock);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = OP_SHL;
        cmd_bus.cmd_count = 3'd3;
        @(posedge clock);
        @(negedge clock);
        cmd_bus.cmd_valid = 1'b0;
        check("shl3_shifting", MODE, 2'b10);
        #2;
        reset = 1'b0;
        #1;
        check("midop_rst_mode", MODE, 2'b00);
        check("midop_rst_busy", busy, 0);
        check("midop_rst_ready", cmd_bus.cmd_ready, 1);
        check("midop_rst_state", state_dbg, IDLE);
`ifdef SHSEQ_PERF_CNT_EN
        check("perf_count_cleared", op_count, 16'd0);
`endif
        saw_valid = 1'b0;
        @(negedge clock);
        if (cmd_bus.result_valid) saw_valid = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (cmd_bus.result_valid) saw_valid = 1'b1;
        end
        check("midop_no_result", saw_valid, 0);
        run_cmd(OP_LOAD, 4'b0110, 3'd0, lat, res);
        check("post_reset_load", res, 4'b0110);
        check("post_reset_latency", lat, 3);
`ifdef SHSEQ_PERF_CNT_EN
        check("perf_count_after_reset", op_count, 16'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
